// File: rtl/button_pkg.sv
// Shared channel state encoding and default timing constants for the button
// conditioner and its per-channel filter.
package button_pkg;

   typedef enum logic [1:0] {
      REL    = 2'd0,
      CONF_P = 2'd1,
      HELD   = 2'd2,
      CONF_R = 2'd3
   } chan_state_e;

   localparam int unsigned DEF_SAMPLE_DIV    = 32;
   localparam int unsigned DEF_FILTER_DEPTH  = 4;
   localparam int unsigned DEF_STUCK_SAMPLES = 11250;

   localparam int unsigned AGREE_W = 4;
   localparam int unsigned STUCK_W = 14;

   // The conditioned level is low exactly while the channel believes the button is down.
   function automatic logic isPressedState(input chan_state_e s);
      return (s == HELD) || (s == CONF_R);
   endfunction

endpackage

// File: rtl/button_filter_channel.sv
// One button channel: 2-flop synchronizer, tick-sampled confirm FSM and, with
// BUTTON_STUCK_DETECT_EN defined, a held-too-long detector that forces release.
module button_filter_channel
   import button_pkg::*;
#(
   parameter int unsigned FILTER_DEPTH  = DEF_FILTER_DEPTH,
   parameter int unsigned STUCK_SAMPLES = DEF_STUCK_SAMPLES
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic tick_i,
   input  logic pin_i,
   output logic level_o,
   output logic stuck_o
);

   localparam logic [AGREE_W-1:0] AGREE_MAX = AGREE_W'(FILTER_DEPTH);
   localparam logic [AGREE_W-1:0] AGREE_ONE = AGREE_W'(1);

   logic               sync1_q;
   logic               sync2_q;
   chan_state_e        state_q;
   chan_state_e        state_d;
   logic [AGREE_W-1:0] agreeCnt_q;
   logic [AGREE_W-1:0] agreeCnt_d;
   logic               level_q;
   logic               level_d;
   logic               stuck_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
      end
   end

   // A disagreeing sample during confirmation drops back to the origin state,
   // so a glitch shorter than the confirm window never changes the level.
   always_comb begin
      state_d    = state_q;
      agreeCnt_d = agreeCnt_q;
      if (tick_i) begin
         case (state_q)
            REL: begin
               if (!sync2_q) begin
                  state_d    = CONF_P;
                  agreeCnt_d = AGREE_ONE;
               end
            end
            CONF_P: begin
               if (sync2_q) begin
                  state_d    = REL;
                  agreeCnt_d = '0;
               end else if (agreeCnt_q >= AGREE_MAX) begin
                  state_d    = HELD;
                  agreeCnt_d = '0;
               end else begin
                  agreeCnt_d = agreeCnt_q + 1'b1;
               end
            end
            HELD: begin
               if (sync2_q) begin
                  state_d    = CONF_R;
                  agreeCnt_d = AGREE_ONE;
               end
            end
            CONF_R: begin
               if (!sync2_q) begin
                  state_d    = HELD;
                  agreeCnt_d = '0;
               end else if (agreeCnt_q >= AGREE_MAX) begin
                  state_d    = REL;
                  agreeCnt_d = '0;
               end else begin
                  agreeCnt_d = agreeCnt_q + 1'b1;
               end
            end
            default: begin
               state_d    = REL;
               agreeCnt_d = '0;
            end
         endcase
      end
   end

   assign level_d = !isPressedState(state_d) || stuck_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= REL;
         agreeCnt_q <= '0;
         level_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         agreeCnt_q <= agreeCnt_d;
         level_q    <= level_d;
      end
   end

   assign level_o = level_q;

`ifdef BUTTON_STUCK_DETECT_EN
   localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_SAMPLES);

   logic [STUCK_W-1:0] stuckCnt_q;
   logic [STUCK_W-1:0] stuckCnt_d;
   logic               stuck_q;

   // The count survives a bounce through CONF_R so a stuck flag only clears in REL.
   always_comb begin
      stuckCnt_d = stuckCnt_q;
      if (state_d == REL) begin
         stuckCnt_d = '0;
      end else if (tick_i && (state_q == HELD) && (stuckCnt_q < STUCK_MAX)) begin
         stuckCnt_d = stuckCnt_q + 1'b1;
      end
   end

   assign stuck_d = (state_d != REL) && (stuckCnt_d == STUCK_MAX);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stuckCnt_q <= '0;
         stuck_q    <= 1'b0;
      end else begin
         stuckCnt_q <= stuckCnt_d;
         stuck_q    <= stuck_d;
      end
   end

   assign stuck_o = stuck_q;
`else
   assign stuck_d = 1'b0;
   assign stuck_o = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Debounces the Mode and Trip buttons with a shared sample prescaler; define
// BUTTON_STUCK_DETECT_EN to add per-channel stuck-press detection.
module button_conditioner
   import button_pkg::*;
#(
   parameter int unsigned SAMPLE_DIV    = DEF_SAMPLE_DIV,
   parameter int unsigned FILTER_DEPTH  = DEF_FILTER_DEPTH,
   parameter int unsigned STUCK_SAMPLES = DEF_STUCK_SAMPLES
) (
   input  logic       HCLK,
   input  logic       HRESETn,
   input  logic       Mode_Pin,
   input  logic       Trip_Pin,
   output logic       Mode,
   output logic       Trip,
   output logic [1:0] Stuck
);

   localparam logic [7:0] DIV_LAST = 8'(SAMPLE_DIV - 1);

   logic [7:0] prescale_q;
   logic [7:0] prescale_d;
   logic       tick;

   assign tick       = (prescale_q == DIV_LAST);
   assign prescale_d = tick ? 8'd0 : prescale_q + 8'd1;

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         prescale_q <= 8'd0;
      end else begin
         prescale_q <= prescale_d;
      end
   end

   button_filter_channel #(
      .FILTER_DEPTH  (FILTER_DEPTH),
      .STUCK_SAMPLES (STUCK_SAMPLES)
   ) uMode (
      .clk_i   (HCLK),
      .rst_ni  (HRESETn),
      .tick_i  (tick),
      .pin_i   (Mode_Pin),
      .level_o (Mode),
      .stuck_o (Stuck[0])
   );

   button_filter_channel #(
      .FILTER_DEPTH  (FILTER_DEPTH),
      .STUCK_SAMPLES (STUCK_SAMPLES)
   ) uTrip (
      .clk_i   (HCLK),
      .rst_ni  (HRESETn),
      .tick_i  (tick),
      .pin_i   (Trip_Pin),
      .level_o (Trip),
      .stuck_o (Stuck[1])
   );

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: press, glitch, bounce, simultaneous
// press, resets mid-press and the BUTTON_STUCK_DETECT_EN stuck path.
module tb_button_conditioner;

   localparam int SAMPLE_DIV     = 32;
   localparam int FILTER_DEPTH   = 4;
   localparam int STUCK_SAMPLES  = 16;
   localparam int CONFIRM_CYCLES = SAMPLE_DIV * FILTER_DEPTH;

   logic       HCLK     = 1'b0;
   logic       HRESETn  = 1'b0;
   logic       Mode_Pin = 1'b1;
   logic       Trip_Pin = 1'b1;
   logic       Mode;
   logic       Trip;
   logic [1:0] Stuck;

   int cyc        = 0;
   int resetRef   = 0;
   int checkCount = 0;
   int errorCount = 0;

   int   modeFalls, modeRises, tripFalls, tripRises, tripLowCycles, stuckSeen;
   int   modeFallCyc, modeRiseCyc, tripFallCyc, tripRiseCyc, stuckSetCyc, stuckClrCyc;
   logic prevMode, prevTrip, prevStuck0;

   button_conditioner #(
      .SAMPLE_DIV    (SAMPLE_DIV),
      .FILTER_DEPTH  (FILTER_DEPTH),
      .STUCK_SAMPLES (STUCK_SAMPLES)
   ) dut (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .Mode_Pin (Mode_Pin),
      .Trip_Pin (Trip_Pin),
      .Mode     (Mode),
      .Trip     (Trip),
      .Stuck    (Stuck)
   );

   always #5 HCLK = ~HCLK;

   always @(posedge HCLK) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Tick edges fall every SAMPLE_DIV edges counted from the last reset edge.
   function automatic int nextTick(input int e);
      int d;
      d = e - resetRef;
      if (d <= SAMPLE_DIV) return resetRef + SAMPLE_DIV;
      return resetRef + ((d + SAMPLE_DIV - 1) / SAMPLE_DIV) * SAMPLE_DIV;
   endfunction

   // Pin driven just after edge k reaches the FSM at edge k+3, then needs the
   // entry tick plus FILTER_DEPTH further agreeing ticks.
   function automatic int expectEdge(input int k);
      return nextTick(k + 3) + CONFIRM_CYCLES;
   endfunction

   task automatic clearEdges();
      modeFalls = 0; modeRises = 0; tripFalls = 0; tripRises = 0;
      tripLowCycles = 0; stuckSeen = 0;
      modeFallCyc = -1; modeRiseCyc = -1; tripFallCyc = -1; tripRiseCyc = -1;
      stuckSetCyc = -1; stuckClrCyc = -1;
      prevMode = Mode; prevTrip = Trip; prevStuck0 = Stuck[0];
   endtask

   task automatic trackOutputs();
      if (prevMode && !Mode) begin modeFalls++; if (modeFallCyc < 0) modeFallCyc = cyc; end
      if (!prevMode && Mode) begin modeRises++; if (modeRiseCyc < 0) modeRiseCyc = cyc; end
      if (prevTrip && !Trip) begin tripFalls++; if (tripFallCyc < 0) tripFallCyc = cyc; end
      if (!prevTrip && Trip) begin tripRises++; if (tripRiseCyc < 0) tripRiseCyc = cyc; end
      if (!Trip) tripLowCycles++;
      if (Stuck != 2'b00) stuckSeen++;
      if (!prevStuck0 && Stuck[0] && stuckSetCyc < 0) stuckSetCyc = cyc;
      if (prevStuck0 && !Stuck[0] && stuckClrCyc < 0) stuckClrCyc = cyc;
      prevMode = Mode; prevTrip = Trip; prevStuck0 = Stuck[0];
   endtask

   task automatic applyStimulus(input logic modePin, input logic tripPin, input int cycles);
      Mode_Pin = modePin;
      Trip_Pin = tripPin;
      for (int i = 0; i < cycles; i++) begin
         @(posedge HCLK);
         #1;
         trackOutputs();
      end
   endtask

   task automatic pulseReset();
      HRESETn = 1'b0;
      @(posedge HCLK);
      #1;
      HRESETn  = 1'b1;
      resetRef = cyc;
   endtask

   initial begin
      int k, k2, t1, h, lat;

      HRESETn = 1'b0;
      repeat (3) @(posedge HCLK);
      #1;
      checkOutput("resetMode", int'(Mode), 1);
      checkOutput("resetTrip", int'(Trip), 1);
      checkOutput("resetStuck", int'(Stuck), 0);
      HRESETn  = 1'b1;
      resetRef = cyc;
      applyStimulus(1'b1, 1'b1, 10);

      // Clean press and release on Mode.
      clearEdges();
      k = cyc;
      applyStimulus(1'b0, 1'b1, 200);
      k2 = cyc;
      applyStimulus(1'b1, 1'b1, 200);
      lat = modeFallCyc - k;
      checkOutput("cleanFallLatency", lat, expectEdge(k) - k);
      checkOutput("cleanFallWindow", int'(lat >= 130 && lat <= 162), 1);
      checkOutput("cleanRiseCycle", modeRiseCyc, expectEdge(k2));
      checkOutput("cleanRiseWindow", int'(modeRiseCyc - k2 <= 162 && modeRiseCyc > k2), 1);
      checkOutput("cleanEdgeCount", modeFalls + modeRises, 2);

      // Two-tick glitch on Trip must never reach the output.
      clearEdges();
      applyStimulus(1'b1, 1'b0, 40);
      applyStimulus(1'b1, 1'b1, 100);
      checkOutput("glitchTripLowCycles", tripLowCycles, 0);

      // Bounce on Mode then steady low: one fall, no rise until release.
      clearEdges();
      for (int i = 0; i < 5; i++) applyStimulus((i % 2 == 0) ? 1'b0 : 1'b1, 1'b1, 10);
      applyStimulus(1'b0, 1'b1, 300);
      checkOutput("bounceFalls", modeFalls, 1);
      checkOutput("bounceRises", modeRises, 0);
      applyStimulus(1'b1, 1'b1, 200);
      checkOutput("bounceReleaseRises", modeRises, 1);

      // Simultaneous press; exact Trip timing also shows it returned to REL after the glitch.
      clearEdges();
      k = cyc;
      applyStimulus(1'b0, 1'b0, 300);
      checkOutput("simModeFall", modeFallCyc, expectEdge(k));
      checkOutput("simTripFall", tripFallCyc, expectEdge(k));
      k2 = cyc;
      applyStimulus(1'b1, 1'b1, 200);
      checkOutput("simModeRise", modeRiseCyc, expectEdge(k2));
      checkOutput("simTripRise", tripRiseCyc, expectEdge(k2));

      // Reset three ticks into CONF_P restarts confirmation from scratch.
      clearEdges();
      k  = cyc;
      t1 = nextTick(k + 3);
      applyStimulus(1'b0, 1'b1, t1 + 2 * SAMPLE_DIV + 5 - cyc);
      pulseReset();
      checkOutput("midConfirmResetMode", int'(Mode), 1);
      checkOutput("midConfirmResetTrip", int'(Trip), 1);
      clearEdges();
      applyStimulus(1'b0, 1'b1, 200);
      checkOutput("reconfirmFall", modeFallCyc, resetRef + SAMPLE_DIV + CONFIRM_CYCLES);
      checkOutput("heldBeforeReset", int'(Mode), 0);

      // Reset while HELD releases the output on the very next cycle.
      pulseReset();
      checkOutput("heldResetMode", int'(Mode), 1);
      clearEdges();
      applyStimulus(1'b1, 1'b1, 300);
      checkOutput("afterHeldResetFalls", modeFalls, 0);

      // Long hold: stuck detection when enabled, otherwise the level stays low.
      clearEdges();
      k = cyc;
      h = expectEdge(k);
      applyStimulus(1'b0, 1'b1, 200);
      applyStimulus(1'b0, 1'b1, 600);
      checkOutput("longHoldFall", modeFallCyc, h);
`ifdef BUTTON_STUCK_DETECT_EN
      checkOutput("stuckSetCycle", stuckSetCyc, h + STUCK_SAMPLES * SAMPLE_DIV);
      checkOutput("stuckForcedRise", modeRiseCyc, h + STUCK_SAMPLES * SAMPLE_DIV);
      checkOutput("stuckValue", int'(Stuck), 1);
      clearEdges();
      k2 = cyc;
      applyStimulus(1'b1, 1'b1, 300);
      checkOutput("stuckClearCycle", stuckClrCyc, expectEdge(k2));
      checkOutput("stuckReleaseFalls", modeFalls, 0);
`else
      checkOutput("noStuckSeen", stuckSeen, 0);
      checkOutput("longHoldRises", modeRises, 0);
      clearEdges();
      k2 = cyc;
      applyStimulus(1'b1, 1'b1, 300);
      checkOutput("longHoldRelease", modeRiseCyc, expectEdge(k2));
`endif

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
